// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt pending / arbitration path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package irq_pkg;

    localparam int N_IRQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_t;

    // One-hot mask selecting the pending bit of a granted line.
    function automatic logic [N_IRQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_IRQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority encoder: index of the highest set input bit (bit 3 wins).
// Latency: combinational.
// Backpressure: none; valid simply flags a non-zero input.
`timescale 1ns/1ps
module priority_encoder (
    input  logic [3:0] in,
    output logic [1:0] out,
    output logic       valid
);

    // Highest set bit wins; out is 0 when nothing is set.
    always_comb begin
        valid = |in;
        out   = 2'd0;
        if (in[3])      out = 2'd3;
        else if (in[2]) out = 2'd2;
        else if (in[1]) out = 2'd1;
        else            out = 2'd0;
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Synchronises 4 async irq lines, latches edges/levels into pending, grants highest unmasked line.
// Latency: irq_in before edge k -> pending after k+2 -> irq_req/irq_id after k+3.
// Backpressure: one grant outstanding at a time; held (no pre-emption) until irq_ack.
`timescale 1ns/1ps
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter logic [N_IRQ-1:0] EDGE_MODE = 4'b1111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             irq_ack,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_IRQ-1:0] pending
);

    logic [N_IRQ-1:0] s1_q, s2_q, s2_prev_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] rise, clr, masked;
    logic [ID_W-1:0]  enc_out;
    logic             enc_vld;
    irq_state_t       state_q, state_d;
    logic             req_q, req_d;
    logic [ID_W-1:0]  id_q, id_d;

    // Two-flop synchroniser plus one extra stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s2_prev_q <= '0;
        end else begin
            s1_q      <= irq_in;
            s2_q      <= s1_q;
            s2_prev_q <= s2_q;
        end
    end

    // Edge lines are sticky until acked (a new edge beats a same-cycle ack);
    // level lines just mirror the synchronised input.
    always_comb begin
        rise      = s2_q & ~s2_prev_q;
        clr       = '0;
        if (state_q == REQ && irq_ack) begin
            clr = id_to_onehot(id_q);
        end
        pending_d = (EDGE_MODE & (rise | (pending_q & ~clr))) | (~EDGE_MODE & s2_q);
        masked    = pending_q & ~irq_mask;
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    priority_encoder u_prio (
        .in    (masked),
        .out   (enc_out),
        .valid (enc_vld)
    );

    // Grant FSM: IDLE latches a winner, REQ holds it frozen until ack.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (enc_vld) begin
                    id_d    = enc_out;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                req_d = 1'b1;
                if (irq_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
        end
    end

    assign irq_req = req_q;
    assign irq_id  = id_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed and random checks of irq_pending_ctrl against a behavioural model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_irq_pending_ctrl;
    import irq_pkg::*;

    localparam logic [3:0] EM0 = 4'b1111;
    localparam logic [3:0] EM1 = 4'b0011;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] irq_in   = 4'h0;
    logic [3:0] irq_mask = 4'h0;
    logic       irq_ack  = 1'b0;

    logic       req0, req1;
    logic [1:0] id0, id1;
    logic [3:0] pend0, pend1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_pending_ctrl #(.EDGE_MODE(EM0)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_mask(irq_mask), .irq_ack(irq_ack),
        .irq_req(req0), .irq_id(id0), .pending(pend0)
    );

    irq_pending_ctrl #(.EDGE_MODE(EM1)) dut_lvl (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_mask(irq_mask), .irq_ack(irq_ack),
        .irq_req(req1), .irq_id(id1), .pending(pend1)
    );

    // Reference model: samples[k][0] = input seen at the latest edge,
    // [1] = two edges ago (visible to pending logic), [2] = three edges ago.
    logic [3:0] samples [2][3];
    logic [3:0] m_pend  [2];
    logic       m_busy  [2];
    logic [1:0] m_id    [2];
    logic [3:0] m_em    [2];

    function automatic logic [1:0] top_index(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) samples[k][j] = 4'h0;
            m_pend[k] = 4'h0;
            m_busy[k] = 1'b0;
            m_id[k]   = 2'd0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] old_pend, new_pend, avail;
        logic       newer, older;
        for (int k = 0; k < 2; k++) begin
            old_pend = m_pend[k];
            for (int i = 0; i < 4; i++) begin
                newer = samples[k][1][i];
                older = samples[k][2][i];
                if (m_em[k][i]) begin
                    new_pend[i] = (newer && !older) ||
                                  (old_pend[i] && !(m_busy[k] && irq_ack && int'(m_id[k]) == i));
                end else begin
                    new_pend[i] = newer;
                end
            end
            if (m_busy[k]) begin
                if (irq_ack) m_busy[k] = 1'b0;
            end else begin
                avail = old_pend & ~irq_mask;
                if (avail != 4'h0) begin
                    m_id[k]   = top_index(avail);
                    m_busy[k] = 1'b1;
                end
            end
            m_pend[k]     = new_pend;
            samples[k][2] = samples[k][1];
            samples[k][1] = samples[k][0];
            samples[k][0] = irq_in;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        chk("m_req0",  4'(req0),      4'(m_busy[0]));
        chk("m_id0",   4'(id0),       4'(m_id[0]));
        chk("m_pend0", pend0,         m_pend[0]);
        chk("m_req1",  4'(req1),      4'(m_busy[1]));
        chk("m_id1",   4'(id1),       4'(m_id[1]));
        chk("m_pend1", pend1,         m_pend[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_model();
    endtask

    task automatic pulse(input logic [3:0] v);
        irq_in = v;
        step();
        irq_in = 4'h0;
        step();
        step();
        step();
    endtask

    task automatic ack_once();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        m_em[0] = EM0;
        m_em[1] = EM1;
        model_reset();

        // Reset with all lines high.
        irq_in = 4'hF;
        step();
        step();
        chk("rst_req",  4'(req0), 4'h0);
        chk("rst_id",   4'(id0),  4'h0);
        chk("rst_pend", pend0,    4'h0);
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("rel_pend", pend0, 4'hF);
        chk("rel_req",  4'(req0), 4'h0);
        irq_in = 4'h0;
        step();
        chk("rel_grant_id", 4'(id0), 4'h3);
        for (int i = 0; i < 16; i++) begin
            irq_ack = req0 | req1;
            step();
        end
        irq_ack = 1'b0;
        chk("drain_pend", pend0, 4'h0);
        chk("drain_req",  4'(req0), 4'h0);

        // Single edge on line 1.
        pulse(4'b0010);
        chk("single_req",  4'(req0), 4'h1);
        chk("single_id",   4'(id0),  4'h1);
        chk("single_pend", pend0,    4'b0010);
        ack_once();
        chk("single_ack_req",  4'(req0), 4'h0);
        chk("single_ack_pend", pend0,    4'h0);

        // Priority: lines 2 and 1 together.
        pulse(4'b0110);
        chk("prio_id_first", 4'(id0), 4'h2);
        ack_once();
        chk("prio_gap_req",  4'(req0), 4'h0);
        chk("prio_gap_pend", pend0,    4'b0010);
        step();
        chk("prio_second_req", 4'(req0), 4'h1);
        chk("prio_second_id",  4'(id0),  4'h1);
        ack_once();
        chk("prio_done_pend", pend0, 4'h0);

        // No pre-emption by a later higher-priority edge.
        pulse(4'b0010);
        chk("nopre_id", 4'(id0), 4'h1);
        pulse(4'b1000);
        chk("nopre_hold_req",  4'(req0), 4'h1);
        chk("nopre_hold_id",   4'(id0),  4'h1);
        chk("nopre_hold_pend", pend0,    4'b1010);
        ack_once();
        chk("nopre_after_pend", pend0, 4'b1000);
        step();
        chk("nopre_next_id", 4'(id0), 4'h3);
        ack_once();

        // Mask line 3.
        irq_mask = 4'b1000;
        pulse(4'b1001);
        chk("mask_id",   4'(id0), 4'h0);
        chk("mask_pend", pend0,   4'b1001);
        ack_once();
        chk("mask_pend_kept", pend0, 4'b1000);
        step();
        chk("mask_no_grant", 4'(req0), 4'h0);
        irq_mask = 4'b0000;
        step();
        chk("unmask_req", 4'(req0), 4'h1);
        chk("unmask_id",  4'(id0),  4'h3);
        ack_once();

        // New edge on line 2 lands in the ack cycle of its own grant.
        pulse(4'b0100);
        chk("coll_id", 4'(id0), 4'h2);
        irq_in = 4'b0100;
        step();
        irq_in = 4'h0;
        step();
        ack_once();
        chk("coll_pend_kept", pend0,    4'b0100);
        chk("coll_req_low",   4'(req0), 4'h0);
        step();
        chk("coll_regrant", 4'(id0), 4'h2);
        ack_once();
        chk("coll_done_pend", pend0, 4'h0);

        // Ack while idle changes nothing.
        irq_mask = 4'hF;
        pulse(4'b0010);
        ack_once();
        chk("idle_ack_pend", pend0,    4'b0010);
        chk("idle_ack_req",  4'(req0), 4'h0);
        irq_mask = 4'h0;
        step();
        chk("idle_ack_grant", 4'(id0), 4'h1);

        // Reset while a request is outstanding.
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_req",  4'(req0), 4'h0);
        chk("midrst_pend", pend0,    4'h0);
        chk("midrst_id",   4'(id0),  4'h0);
        step();
        rst_n = 1'b1;

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            irq_in  = 4'($urandom) & 4'($urandom);
            irq_ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) irq_mask = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare_model();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
